dmem_sized_ctrl: RTL
====================

# dmem_sized_ctrl

Parametrised data memory for the pipelined RISC-V core's MEM stage, successor to the fixed 64-word word-only data memory. It supports RV32I sized loads and stores (byte/half/word, signed and unsigned) with byte-lane merging. A valid/ready request handshake with a configurable wait-state count lets the pipeline stall on slow memory. Every access returns a single-cycle response pulse carrying read data and a fault flag.

## Interface
- `ADDR_W`, 8: byte-address width; depth = 2**(ADDR_W-2) 32-bit words.
- `LATENCY`, 1: wait cycles inserted before an access commits; range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (size/sign).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: request rejected with no memory effect.

## Operation
- States: IDLE, BUSY, RESP. `req_ready` = (state==IDLE or state==RESP).
- Accept on a rising edge with `req_valid && req_ready`: latch we/funct3/addr/wdata, set cnt=LATENCY, go to BUSY.
- BUSY with cnt!=0: decrement cnt. BUSY with cnt==0: perform the access at this edge, register the response, go to RESP.
- RESP: `rsp_valid`=1. If a new request is accepted, go to BUSY; otherwise go to IDLE.
- funct3 handling:
  - 000 LB/SB: byte lane addr[1:0].
  - 001 LH/SH: half at addr[1].
  - 010 LW/SW: full word.
  - 100 LBU, 101 LHU: zero-extended loads.
  - LB/LH are sign-extended.
  - 100/101 with we=1, and 011/110/111 always, are illegal: fault, no write.
- Stores write only the addressed lanes through byte enables; the other bytes of the word are unchanged.
- `rsp_rdata`/`rsp_fault` are registered and hold until the next response. They are valid only while `rsp_valid`=1.
- Memory contents are not reset. Power-up preload: word0=17, word1=9, word2=25, all other words 0.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, cnt=0.
- Request accepted at edge E: the access commits and `rsp_valid` rises at edge E+1+LATENCY and stays high for exactly one cycle.
- Back-to-back requests: one per LATENCY+2 cycles (accept during RESP).
- Reset mid-BUSY: the request is dropped and no write occurs. Reset in the same cycle as a commit edge: the asynchronous reset wins and no write occurs.
- `req_valid` while not ready: ignored. The requester holds the request until accepted.
- Address wrap-around cannot occur; every ADDR_W value maps to a word.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - half access with addr[0]=1, or word access with addr[1:0]!=0 → `rsp_fault`=1, `rsp_rdata`=0, no write.
  - Response timing is unchanged.
- Undefined:
  - low address bits below the access size are ignored (access forced aligned).
  - Only illegal funct3 raises a fault.

## Structure
- Package `dmem_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state encoding.
  - `LATENCY` width constant (4).
- Sub-module `dmem_lane_align`, combinational:
  - From funct3, addr[1:0] and wdata/word, it produces the 4-bit byte enable, the merged store word, the extended load value and the misalign/illegal flags.
- Top level contains the FSM, counter, storage array and response registers.

## Test plan
- Reset, then LW addr 0x04, LATENCY=1 → `rsp_valid` at accept+2, `rsp_rdata`=9, fault=0.
- SW 0xDEADBEEF to 0x10, then LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x55 to 0x11 over 0xDEADBEEF at 0x10, then LW 0x10 → 0xDEAD55EF.
- With `DMEM_MISALIGN_CHECK_EN`: SW 0x12345678 to 0x06 → fault=1, then LW 0x04 still returns 9. Without the macro: LW 0x06 → 9, fault=0.
- funct3=011 load, and funct3=100 with we=1 → fault=1, `rsp_rdata`=0, memory unchanged.
- LATENCY=3: assert `rst_n`=0 two cycles after accepting SW 0xAA to 0x08, release, then LW 0x08 → 25 (write dropped). `req_ready`=1 and `rsp_valid`=0 during reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the sized data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I sized loads/stores.
// Build option: DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into faults.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_val,
  output logic        misalign,
  output logic        illegal
);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHECK_MISALIGN = 1'b1;
`else
  localparam bit CHECK_MISALIGN = 1'b0;
`endif

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        misalign_raw;

  always_comb begin
    byte_en      = 4'b0000;
    store_word   = 32'd0;
    load_val     = 32'd0;
    illegal      = 1'b0;
    misalign_raw = 1'b0;
    sel_byte     = 8'(word >> {addr_lo, 3'b000});
    sel_half     = addr_lo[1] ? word[31:16] : word[15:0];
    unique case (funct3)
      F3_B, F3_BU: begin
        // Replicate the store byte on every lane; byte_en picks the real one.
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{wdata[7:0]}};
        load_val   = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
        illegal    = we && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        byte_en      = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word   = {2{wdata[15:0]}};
        load_val     = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
        illegal      = we && (funct3 == F3_HU);
        misalign_raw = addr_lo[0];
      end
      F3_W: begin
        byte_en      = 4'b1111;
        store_word   = wdata;
        load_val     = word;
        misalign_raw = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
    misalign = CHECK_MISALIGN && misalign_raw;
  end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Sized-access data memory with valid/ready request, wait states and a one-cycle response pulse.
// Build option: DMEM_MISALIGN_CHECK_EN (handled in dmem_lane_align).
import dmem_pkg::*;

module dmem_sized_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

  state_t            state_reg, state_next;
  logic [LAT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  // Contents survive reset; only the power-up image is defined.
  logic [31:0] mem_array [DEPTH] = '{0: 32'd17, 1: 32'd9, 2: 32'd25, default: 32'd0};

  logic        accept, commit, fault;
  logic [31:0] word_rd, store_word, load_val;
  logic [3:0]  byte_en;
  logic        misalign, illegal;

  assign req_ready = (state_reg == ST_IDLE) || (state_reg == ST_RESP);
  assign rsp_valid = (state_reg == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_reg == ST_BUSY) && (cnt_reg == '0);
  assign word_rd   = mem_array[addr_reg[ADDR_W-1:2]];
  assign fault     = illegal || misalign;

  dmem_lane_align u_align (
    .funct3    (f3_reg),
    .we        (we_reg),
    .addr_lo   (addr_reg[1:0]),
    .wdata     (wdata_reg),
    .word      (word_rd),
    .byte_en   (byte_en),
    .store_word(store_word),
    .load_val  (load_val),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_BUSY;
          cnt_next   = LAT_INIT;
        end
      end
      ST_BUSY: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - LAT_W'(1);
        else               state_next = ST_RESP;
      end
      ST_RESP: begin
        if (accept) begin
          state_next = ST_BUSY;
          cnt_next   = LAT_INIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      f3_reg    <= 3'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        f3_reg    <= req_funct3;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (commit) begin
        rsp_fault <= fault;
        rsp_rdata <= (fault || we_reg) ? 32'd0 : load_val;
      end
    end
  end

  // rst_n gating keeps a reset that coincides with the commit edge from writing.
  always_ff @(posedge clk) begin
    if (commit && rst_n && we_reg && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_array[addr_reg[ADDR_W-1:2]][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

endmodule
